// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller -- multicycle Moore control FSM for a byte-fetch MIPS-like datapath
//
// The instruction word is fetched one byte per cycle over four FETCH states,
// then decoded and executed over one to three further states. Every output is
// a pure function of the current state, except pcen, which also folds in the
// ALU zero flag while a branch is being evaluated.
//
// Optional feature macro: ADDI_EN
//   defined   : addi (op 001000) executes through ADDIEX / ADDIWR
//   undefined : op 001000 is treated as an illegal opcode (DECODE -> FETCH1)
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset, returns the FSM to FETCH1
//   op        in   6  opcode field from the instruction register
//   zero      in   1  ALU zero flag, only meaningful during BEQEX
//   memread   out  1  memory read strobe
//   memwrite  out  1  memory write strobe
//   alusrca   out  1  ALU port A source: 0 = PC, 1 = register A
//   memtoreg  out  1  register write data: 1 = memory data
//   iord      out  1  memory address: 0 = PC, 1 = ALU result
//   pcen      out  1  PC load enable
//   regwrite  out  1  register file write enable
//   regdst    out  1  write register: 1 = rd, 0 = rt
//   pcsource  out  2  00 ALU result, 01 ALU out register, 10 jump target
//   alusrcb   out  2  00 B, 01 const 1, 10 imm, 11 imm branch offset
//   aluop     out  2  00 add, 01 sub, 10 decode funct
//   irwrite   out  4  one-hot byte enable for instruction register bytes 0..3
// -----------------------------------------------------------------------------
module controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       memread,
   output logic       memwrite,
   output logic       alusrca,
   output logic       memtoreg,
   output logic       iord,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic [1:0] pcsource,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [3:0] irwrite
);

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   // Encoding 4'd15 (and 13/14 without addi) is never entered; if upset
   // logic ever lands there the default arm drives all outputs low and
   // returns to FETCH1.
   typedef enum logic [3:0] {
      FETCH1  = 4'd0,
      FETCH2  = 4'd1,
      FETCH3  = 4'd2,
      FETCH4  = 4'd3,
      DECODE  = 4'd4,
      MEMADR  = 4'd5,
      LBRD    = 4'd6,
      LBWR    = 4'd7,
      SBWR    = 4'd8,
      RTYPEEX = 4'd9,
      RTYPEWR = 4'd10,
      BEQEX   = 4'd11,
`ifdef ADDI_EN
      JEX     = 4'd12,
      ADDIEX  = 4'd13,
      ADDIWR  = 4'd14
`else
      JEX     = 4'd12
`endif
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Internal strobes that combine into pcen.
   logic pcwrite;
   logic branch;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= FETCH1;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and Moore output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = FETCH1;
      memread    = 1'b0;
      memwrite   = 1'b0;
      alusrca    = 1'b0;
      memtoreg   = 1'b0;
      iord       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      pcsource   = 2'b00;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      irwrite    = 4'b0000;

      case (state_reg)
         // Byte fetch: read memory at PC, latch one IR byte, PC <= PC + 1.
         FETCH1: begin
            memread    = 1'b1;
            alusrcb    = 2'b01;
            pcwrite    = 1'b1;
            irwrite    = 4'b0001;
            state_next = FETCH2;
         end
         FETCH2: begin
            memread    = 1'b1;
            alusrcb    = 2'b01;
            pcwrite    = 1'b1;
            irwrite    = 4'b0010;
            state_next = FETCH3;
         end
         FETCH3: begin
            memread    = 1'b1;
            alusrcb    = 2'b01;
            pcwrite    = 1'b1;
            irwrite    = 4'b0100;
            state_next = FETCH4;
         end
         FETCH4: begin
            memread    = 1'b1;
            alusrcb    = 2'b01;
            pcwrite    = 1'b1;
            irwrite    = 4'b1000;
            state_next = DECODE;
         end

         // Precompute the branch target while the opcode is examined.
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LB, OP_SB: state_next = MEMADR;
               OP_RTYPE:     state_next = RTYPEEX;
               OP_BEQ:       state_next = BEQEX;
               OP_J:         state_next = JEX;
`ifdef ADDI_EN
               OP_ADDI:      state_next = ADDIEX;
`endif
               default:      state_next = FETCH1;
            endcase
         end

         // Only lb and sb reach here, so anything that is not lb is a store.
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = (op == OP_LB) ? LBRD : SBWR;
         end

         LBRD: begin
            memread    = 1'b1;
            iord       = 1'b1;
            state_next = LBWR;
         end
         LBWR: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            state_next = FETCH1;
         end

         SBWR: begin
            memwrite   = 1'b1;
            iord       = 1'b1;
            state_next = FETCH1;
         end

         RTYPEEX: begin
            alusrca    = 1'b1;
            aluop      = 2'b10;
            state_next = RTYPEWR;
         end
         RTYPEWR: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            state_next = FETCH1;
         end

         // Compare A and B; the target computed in DECODE sits in ALUOut.
         BEQEX: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            branch     = 1'b1;
            pcsource   = 2'b01;
            state_next = FETCH1;
         end

         JEX: begin
            pcwrite    = 1'b1;
            pcsource   = 2'b10;
            state_next = FETCH1;
         end

`ifdef ADDI_EN
         ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = ADDIWR;
         end
         ADDIWR: begin
            regwrite   = 1'b1;
            state_next = FETCH1;
         end
`endif

         default: begin
            state_next = FETCH1;
         end
      endcase
   end

   // branch is only ever set in BEQEX, so zero has no effect elsewhere.
   assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller -- self-checking bench for the controller FSM
//
// A reference model describes each instruction as a position within its
// instruction (cycle 0..len-1) plus an instruction class chosen from op when
// the decode step completes. Expected outputs are looked up from that pair and
// compared against the DUT on every falling edge. Directed tasks add literal
// checks on latency and on key strobes. Define ADDI_EN for both the DUT and
// the bench to exercise the addi path.
// -----------------------------------------------------------------------------
module tb_controller;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
   logic [1:0] pcsource, alusrcb, aluop;
   logic [3:0] irwrite;

   controller dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .zero     (zero),
      .memread  (memread),
      .memwrite (memwrite),
      .alusrca  (alusrca),
      .memtoreg (memtoreg),
      .iord     (iord),
      .pcen     (pcen),
      .regwrite (regwrite),
      .regdst   (regdst),
      .pcsource (pcsource),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .irwrite  (irwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       alusrca;
      logic       memtoreg;
      logic       iord;
      logic       pcen;
      logic       regwrite;
      logic       regdst;
      logic [1:0] pcsource;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [3:0] irwrite;
   } out_t;

   // Instruction classes used by the model.
   localparam int K_NONE = 0;
   localparam int K_LB   = 1;
   localparam int K_SB   = 2;
   localparam int K_R    = 3;
   localparam int K_BEQ  = 4;
   localparam int K_J    = 5;
   localparam int K_ADDI = 6;
   localparam int K_ILL  = 7;

   function automatic int classify(logic [5:0] o);
      case (o)
         6'b100000: return K_LB;
         6'b101000: return K_SB;
         6'b000000: return K_R;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
`ifdef ADDI_EN
         6'b001000: return K_ADDI;
`endif
         default:   return K_ILL;
      endcase
   endfunction

   // Total cycles per instruction, fetch included.
   function automatic int klen(int k);
      case (k)
         K_LB:    return 8;
         K_SB:    return 7;
         K_R:     return 7;
         K_ADDI:  return 7;
         K_BEQ:   return 6;
         K_J:     return 6;
         K_ILL:   return 5;
         default: return 99;
      endcase
   endfunction

   // Class after the step at position c completes: decided at decode,
   // refined between load and store at the address step.
   function automatic int step_kind(int c, int k, logic [5:0] o);
      if (c == 4) return classify(o);
      if (c == 5 && (k == K_LB || k == K_SB)) return (o == 6'b100000) ? K_LB : K_SB;
      return k;
   endfunction

   function automatic out_t exp_out(int k, int c, logic z);
      out_t e;
      e = '0;
      if (c < 4) begin
         e.memread = 1'b1;
         e.alusrcb = 2'b01;
         e.pcen    = 1'b1;
         e.irwrite = 4'(1 << c);
      end else if (c == 4) begin
         e.alusrcb = 2'b11;
      end else begin
         case (k)
            K_LB, K_SB: begin
               if (c == 5) begin
                  e.alusrca = 1'b1; e.alusrcb = 2'b10;
               end else if (c == 6 && k == K_LB) begin
                  e.memread = 1'b1; e.iord = 1'b1;
               end else if (c == 6) begin
                  e.memwrite = 1'b1; e.iord = 1'b1;
               end else if (c == 7) begin
                  e.regwrite = 1'b1; e.memtoreg = 1'b1;
               end
            end
            K_R: begin
               if (c == 5) begin
                  e.alusrca = 1'b1; e.aluop = 2'b10;
               end else begin
                  e.regdst = 1'b1; e.regwrite = 1'b1;
               end
            end
            K_ADDI: begin
               if (c == 5) begin
                  e.alusrca = 1'b1; e.alusrcb = 2'b10;
               end else begin
                  e.regwrite = 1'b1;
               end
            end
            K_BEQ: begin
               e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z;
            end
            K_J: begin
               e.pcen = 1'b1; e.pcsource = 2'b10;
            end
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   // Model state.
   int   m_cyc   = 0;
   int   m_kind  = K_NONE;
   logic m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_cyc   <= 0;
         m_kind  <= K_NONE;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         if (m_cyc + 1 == klen(step_kind(m_cyc, m_kind, op))) begin
            m_cyc  <= 0;
            m_kind <= K_NONE;
         end else begin
            m_cyc  <= m_cyc + 1;
            m_kind <= step_kind(m_cyc, m_kind, op);
         end
      end
   end

   out_t got;
   assign got = '{memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
                  regdst, pcsource, alusrcb, aluop, irwrite};

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
      checks++;
      if (actual !== expect_v) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expect_v, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_outputs", 32'(got), 32'(exp_out(m_kind, m_cyc, zero)));
      end
   end

   // Inputs change 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Runs one instruction starting in FETCH1. op1 is held through decode,
   // op2 applies from the address/execute step onward.
   task automatic run_instr(input string name, input logic [5:0] op1, input logic [5:0] op2,
                            input logic z, input int exp_len, input logic exp_rw,
                            input logic exp_br);
      int   n;
      logic saw_rw;
      logic saw_br;
      n = 0; saw_rw = 1'b0; saw_br = 1'b0;
      op = op1;
      zero = z;
      chk({name, "_start_fetch1"}, 32'(irwrite), 32'h1);
      do begin
         step();
         n++;
         if (n == 5) op = op2;
         if (regwrite) saw_rw = 1'b1;
         if (pcen && pcsource == 2'b01) saw_br = 1'b1;
      end while (irwrite != 4'b0001 && n < 20);
      chk({name, "_latency"}, 32'(n), 32'(exp_len));
      chk({name, "_regwrite_seen"}, 32'(saw_rw), 32'(exp_rw));
      chk({name, "_branch_pcen"}, 32'(saw_br), 32'(exp_br));
      $display("instr %s op=%b/%b zero=%b cycles=%0d", name, op1, op2, z, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      op    = 6'b111111;
      zero  = 1'b0;

      // Reset held for two edges; FETCH1 decode visible after the first.
      step();
      chk("rst_irwrite",  32'(irwrite),  32'h1);
      chk("rst_memread",  32'(memread),  32'h1);
      chk("rst_alusrcb",  32'(alusrcb),  32'h1);
      chk("rst_pcen",     32'(pcen),     32'h1);
      chk("rst_regwrite", 32'(regwrite), 32'h0);
      step();
      reset = 1'b0;
      chk("fetch1_irwrite", 32'(irwrite), 32'h1);
      step();
      chk("fetch2_irwrite", 32'(irwrite), 32'h2);
      chk("fetch2_pcen",    32'(pcen),    32'h1);
      step();
      chk("fetch3_irwrite", 32'(irwrite), 32'h4);
      step();
      chk("fetch4_irwrite", 32'(irwrite), 32'h8);
      chk("fetch4_pcen",    32'(pcen),    32'h1);
      step();
      chk("decode_alusrcb", 32'(alusrcb), 32'h3);
      step();
      // op 111111 is illegal: straight back to FETCH1 after decode.
      chk("illegal_back_fetch1", 32'(irwrite), 32'h1);
      $display("instr reset_and_illegal op=111111 cycles=5");

      run_instr("lb",        6'b100000, 6'b100000, 1'b0, 8, 1'b1, 1'b0);
      run_instr("sb",        6'b101000, 6'b101000, 1'b0, 7, 1'b0, 1'b0);
      run_instr("rtype",     6'b000000, 6'b000000, 1'b0, 7, 1'b1, 1'b0);
      run_instr("beq_taken", 6'b000100, 6'b000100, 1'b1, 6, 1'b0, 1'b1);
      run_instr("beq_not",   6'b000100, 6'b000100, 1'b0, 6, 1'b0, 1'b0);
      run_instr("j",         6'b000010, 6'b000010, 1'b1, 6, 1'b0, 1'b0);
`ifdef ADDI_EN
      run_instr("addi",      6'b001000, 6'b001000, 1'b0, 7, 1'b1, 1'b0);
`else
      run_instr("addi_off",  6'b001000, 6'b001000, 1'b0, 5, 1'b0, 1'b0);
`endif
      run_instr("illegal",   6'b111111, 6'b111111, 1'b0, 5, 1'b0, 1'b0);
      // op re-sampled at the address step: lb at decode, sb at MEMADR.
      run_instr("lb_to_sb",  6'b100000, 6'b101000, 1'b0, 7, 1'b0, 1'b0);
      // op changes after decode do not affect an R-type.
      run_instr("rtype_chg", 6'b000000, 6'b111111, 1'b0, 7, 1'b1, 1'b0);

      // Reset in RTYPEEX abandons the instruction before its write-back.
      op = 6'b000000;
      zero = 1'b0;
      repeat (5) step();
      chk("rtypeex_aluop",   32'(aluop),   32'h2);
      chk("rtypeex_alusrca", 32'(alusrca), 32'h1);
      reset = 1'b1;
      step();
      chk("midrst_irwrite",  32'(irwrite),  32'h1);
      chk("midrst_regwrite", 32'(regwrite), 32'h0);
      chk("midrst_regdst",   32'(regdst),   32'h0);
      reset = 1'b0;
      op = 6'b111111;
      step();
      chk("midrst_fetch2",   32'(irwrite),  32'h2);
      chk("midrst_no_rw",    32'(regwrite), 32'h0);
      $display("instr rtype_reset_mid op=000000 aborted");
      repeat (4) step();
      run_instr("after_rst_j", 6'b000010, 6'b000010, 1'b0, 6, 1'b0, 1'b0);

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 reset  input  1  synchronous, active-high reset; one clock, one reset.
REQ-003 op  input  6  instruction opcode field from instruction register.
REQ-004 zero  input  1  ALU zero flag; used only for beq.
REQ-005 memread  output  1  memory read strobe.
REQ-006 memwrite  output  1  memory write strobe.
REQ-007 alusrca  output  1  0=PC, 1=register A to ALU port A.
REQ-008 memtoreg  output  1  1=memory data to register write port.
REQ-009 iord  output  1  0=PC, 1=ALU result as memory address.
REQ-010 pcen  output  1  PC load enable.
REQ-011 regwrite  output  1  register file write enable.
REQ-012 regdst  output  1  1=rd, 0=rt as write register.
REQ-013 pcsource  output  2  00=ALU result, 01=ALU out register, 10=jump target.
REQ-014 alusrcb  output  2  00=B, 01=constant 1, 10=imm, 11=imm branch offset.
REQ-015 aluop  output  2  00=add, 01=sub, 10=decode funct; feeds the ALU control decoder.
REQ-016 irwrite  output  4  one-hot byte enable for instruction register bytes 0..3.

Function
REQ-017 Multicycle Moore FSM, 4-bit state register; all outputs decoded from state only, except pcen.
REQ-018 States: FETCH1-FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
REQ-019 FETCHn (n=1..4): memread=1, alusrcb=01, pcwrite=1, irwrite bit n-1 set; FETCHn -> FETCHn+1; FETCH4 -> DECODE.
REQ-020 DECODE: alusrcb=11; next by op: 100000 lb or 101000 sb -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 000010 -> JEX, 001000 -> ADDIEX; any other op -> FETCH1.
REQ-021 MEMADR: alusrca=1, alusrcb=10; op 100000 -> LBRD, otherwise -> SBWR.
REQ-022 LBRD: memread=1, iord=1 -> LBWR; LBWR: regwrite=1, memtoreg=1 -> FETCH1.
REQ-023 SBWR: memwrite=1, iord=1 -> FETCH1.
REQ-024 RTYPEEX: alusrca=1, aluop=10 -> RTYPEWR; RTYPEWR: regdst=1, regwrite=1 -> FETCH1.
REQ-025 BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01 -> FETCH1.
REQ-026 JEX: pcwrite=1, pcsource=10 -> FETCH1.
REQ-027 ADDIEX: alusrca=1, alusrcb=10 -> ADDIWR; ADDIWR: regwrite=1 -> FETCH1.
REQ-028 pcen = pcwrite OR (branch AND zero), combinational; zero ignored outside BEQEX.
REQ-029 Signals not listed for a state are 0; undefined state encodings -> FETCH1 with all outputs 0.
REQ-030 Latency in cycles incl. 4 fetch: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, illegal op 5.
REQ-031 op sampled only in DECODE and MEMADR; op changes in other states have no effect.

Reset
REQ-032 reset=1 at a clock edge forces state FETCH1 from any state, including mid-instruction; no partial write is completed.
REQ-033 Outputs after reset edge equal FETCH1 decode: memread=1, alusrcb=01, irwrite=0001, pcen=1, all others 0.

Configuration
REQ-034 Macro ADDI_EN defined: ADDIEX/ADDIWR present, op 001000 per REQ-020/027.
REQ-035 ADDI_EN undefined: ADDIEX/ADDIWR absent, op 001000 treated as illegal (DECODE -> FETCH1).

Verification
REQ-036 reset high 2 cycles, release -> state FETCH1, irwrite 0001, then 0010, 0100, 1000 on next three edges, pcen=1 all four.
REQ-037 op=100000 -> DECODE, MEMADR, LBRD (iord=1, memread=1), LBWR (regwrite=1, memtoreg=1), FETCH1; 8 cycles total.
REQ-038 op=000100, zero=1 in BEQEX -> pcen=1, pcsource=01, aluop=01; repeat with zero=0 -> pcen=0.
REQ-039 op=001000 -> ADDIEX, ADDIWR (regwrite=1, regdst=0) with ADDI_EN; without -> FETCH1 after DECODE, no regwrite.
REQ-040 op=000000, reset asserted in RTYPEEX -> next state FETCH1, regwrite never asserted; op=111111 -> FETCH1 after DECODE.
